// File: rtl/rv_pkg.sv
// Shared RV32I datapath constants: default word width, operand-select source indices
// and the skid-buffer occupancy encoding.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam int unsigned OPSEL_RF    = 0;
  localparam int unsigned OPSEL_EXMEM = 1;
  localparam int unsigned OPSEL_MEMWB = 2;
  localparam int unsigned OPSEL_IMM   = 3;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccTwo   = 2'd2
  } occ_e;

endpackage

// File: rtl/operand_sel_pipe_if.sv
// Source/select input side and valid/ready output side of operand_sel_pipe.
// master drives sources and consumes output; slave is the selector itself.
interface operand_sel_pipe_if #(
  parameter int unsigned XLEN    = rv_pkg::XLEN,
  parameter int unsigned NUM_SRC = 4
);

  localparam int unsigned SELW = $clog2(NUM_SRC);

  logic [NUM_SRC*XLEN-1:0] src_data;
  logic [SELW-1:0]         sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sel_err;
  logic                    err_sticky;

  modport master (
    output src_data, sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel_err, err_sticky
  );

  modport slave (
    input  src_data, sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel_err, err_sticky
  );

endinterface

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready and out_valid are registered and
// derived from the occupancy state, so there is no path from out_ready to in_ready.
module skid_buf import rv_pkg::*; #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  occ_e         occ_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         valid_q;
  logic         ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= OccEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (occ_q)
        OccEmpty: begin
          if (in_valid) begin
            main_q  <= in_data;
            valid_q <= 1'b1;
            occ_q   <= OccOne;
          end
        end
        OccOne: begin
          // main stays on the output while stalled, so the new word parks in skid
          if (in_valid && !out_ready) begin
            skid_q  <= in_data;
            ready_q <= 1'b0;
            occ_q   <= OccTwo;
          end else if (in_valid) begin
            main_q <= in_data;
          end else if (out_ready) begin
            valid_q <= 1'b0;
            occ_q   <= OccEmpty;
          end
        end
        OccTwo: begin
          if (out_ready) begin
            main_q  <= skid_q;
            ready_q <= 1'b1;
            occ_q   <= OccOne;
          end
        end
        default: begin
          occ_q   <= OccEmpty;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/operand_sel_pipe.sv
// Registered operand selector: binary source-index decode feeding a 2-entry skid buffer.
// Out-of-range select detection is built only when OPSEL_SEL_CHECK_EN is defined.
module operand_sel_pipe #(
  parameter int unsigned XLEN    = rv_pkg::XLEN,
  parameter int unsigned NUM_SRC = 4
) (
  input logic               clk,
  input logic               rst,
  operand_sel_pipe_if.slave bus
);

  localparam int unsigned SELW = $clog2(NUM_SRC);

  logic [XLEN-1:0] sel_word;
  logic            sel_oob;
  logic [XLEN:0]   buf_out;

  // Unmatched select codes fall through to source 0.
  always_comb begin
    sel_word = bus.src_data[XLEN-1:0];
    for (int unsigned k = 1; k < NUM_SRC; k++) begin
      if (bus.sel == SELW'(k)) begin
        sel_word = bus.src_data[k*XLEN +: XLEN];
      end
    end
  end

`ifdef OPSEL_SEL_CHECK_EN
  logic in_fire;
  logic err_sticky_q;

  assign in_fire = bus.in_valid & bus.in_ready;
  assign sel_oob = (32'(bus.sel) >= NUM_SRC);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else if (in_fire && sel_oob) begin
      err_sticky_q <= 1'b1;
    end
  end

  assign bus.err_sticky = err_sticky_q;
`else
  assign sel_oob        = 1'b0;
  assign bus.err_sticky = 1'b0;
`endif

  skid_buf #(
    .W(XLEN + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({sel_oob, sel_word}),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .out_data (buf_out),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready)
  );

  assign bus.out_data    = buf_out[XLEN-1:0];
  assign bus.out_sel_err = buf_out[XLEN];

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Scoreboard bench for operand_sel_pipe over three configurations (32x4, 32x3, 64x5).
// Error-bit expectations follow OPSEL_SEL_CHECK_EN.
module tb_operand_sel_pipe;
  import rv_pkg::*;

`ifdef OPSEL_SEL_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  operand_sel_pipe_if #(.XLEN(32), .NUM_SRC(4)) a_if ();
  operand_sel_pipe_if #(.XLEN(32), .NUM_SRC(3)) b_if ();
  operand_sel_pipe_if #(.XLEN(64), .NUM_SRC(5)) c_if ();

  operand_sel_pipe #(.XLEN(32), .NUM_SRC(4)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  operand_sel_pipe #(.XLEN(32), .NUM_SRC(3)) u_b (.clk(clk), .rst(rst), .bus(b_if));
  operand_sel_pipe #(.XLEN(64), .NUM_SRC(5)) u_c (.clk(clk), .rst(rst), .bus(c_if));

  logic [31:0] sb[$];
  logic [63:0] sbw[$];
  logic [31:0] s[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (a_if.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", a_if.in_ready); end
    n_checks++; if (a_if.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid: got %b want 0", a_if.out_valid); end
    n_checks++; if (a_if.out_data !== 32'h0) begin n_fail++;
      $display("FAIL reset_out_data: got %h want 0", a_if.out_data); end
    n_checks++; if (a_if.out_sel_err !== 1'b0 || a_if.err_sticky !== 1'b0) begin n_fail++;
      $display("FAIL reset_err: got %b%b want 00", a_if.out_sel_err, a_if.err_sticky); end
    n_checks++; if (b_if.in_ready !== 1'b1 || c_if.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready_bc: got %b%b want 11", b_if.in_ready, c_if.in_ready); end
  endtask

  task automatic test_single();
    logic [31:0] exp;
    s = '{32'h11, 32'h22, 32'h33, 32'h44};
    a_if.src_data  = {s[3], s[2], s[1], s[0]};
    a_if.sel       = 2'(OPSEL_MEMWB);
    a_if.out_ready = 1'b1;
    a_if.in_valid  = 1'b1;
    n_checks++; if (a_if.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL single_in_ready: got %b want 1", a_if.in_ready); end
    sb.push_back(s[OPSEL_MEMWB]);
    step();
    a_if.in_valid = 1'b0;
    n_checks++; if (a_if.out_valid !== 1'b1) begin n_fail++;
      $display("FAIL single_latency: out_valid got %b want 1", a_if.out_valid); end
    exp = sb.pop_front();
    n_checks++; if (a_if.out_data !== exp) begin n_fail++;
      $display("FAIL single_data: got %h want %h", a_if.out_data, exp); end
    step();
    n_checks++; if (a_if.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL single_one_cycle: out_valid got %b want 0", a_if.out_valid); end
  endtask

  task automatic test_backpressure();
    int unsigned sels[3] = '{0, 1, 3};
    logic [31:0] exp;
    logic        acc;
    int          got = 0;
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_if.sel      = 2'(sels[i]);
      a_if.in_valid = 1'b1;
      if (i < 2) begin
        n_checks++; if (a_if.in_ready !== 1'b1) begin n_fail++;
          $display("FAIL bp_accept%0d: in_ready got %b want 1", i, a_if.in_ready); end
        sb.push_back(s[sels[i]]);
      end else begin
        n_checks++; if (a_if.in_ready !== 1'b0) begin n_fail++;
          $display("FAIL bp_ready_drop: in_ready got %b want 0", a_if.in_ready); end
      end
      step();
    end
    n_checks++; if (a_if.in_ready !== 1'b0 || a_if.out_data !== 32'h11) begin n_fail++;
      $display("FAIL bp_hold: in_ready %b data %h want 0 11", a_if.in_ready, a_if.out_data); end
    a_if.out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
      acc = a_if.in_valid & a_if.in_ready;
      if (acc) sb.push_back(s[sels[2]]);
      if (a_if.out_valid) begin
        got++;
        n_checks++;
        if (sb.size() == 0) begin n_fail++;
          $display("FAIL bp_extra: got %h want no output", a_if.out_data);
        end else begin
          exp = sb.pop_front();
          if (a_if.out_data !== exp) begin n_fail++;
            $display("FAIL bp_order: got %h want %h", a_if.out_data, exp); end
        end
      end
      step();
      if (acc) a_if.in_valid = 1'b0;
    end
    n_checks++; if (got != 3 || sb.size() != 0) begin n_fail++;
      $display("FAIL bp_drain: got %0d words left %0d want 3 0", got, sb.size()); end
  endtask

  task automatic test_streaming();
    logic [1:0]  sel_r;
    logic [31:0] exp;
    a_if.out_ready = 1'b1;
    for (int cyc = 0; cyc <= 100; cyc++) begin
      if (cyc < 100) begin
        for (int k = 0; k < 4; k++) s[k] = $urandom;
        sel_r          = 2'($urandom_range(3));
        a_if.src_data  = {s[3], s[2], s[1], s[0]};
        a_if.sel       = sel_r;
        a_if.in_valid  = 1'b1;
        n_checks++; if (a_if.in_ready !== 1'b1) begin n_fail++;
          $display("FAIL stream_in_ready c%0d: got %b want 1", cyc, a_if.in_ready); end
        sb.push_back(s[sel_r]);
      end else begin
        a_if.in_valid = 1'b0;
      end
      if (cyc > 0) begin
        n_checks++; if (a_if.out_valid !== 1'b1) begin n_fail++;
          $display("FAIL stream_valid c%0d: got %b want 1", cyc, a_if.out_valid); end
        exp = sb.pop_front();
        n_checks++; if (a_if.out_data !== exp) begin n_fail++;
          $display("FAIL stream_data c%0d: got %h want %h", cyc, a_if.out_data, exp); end
      end
      step();
    end
    n_checks++; if (a_if.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL stream_end: out_valid got %b want 0", a_if.out_valid); end
  endtask

  task automatic test_illegal_sel();
    b_if.src_data  = {32'hC2, 32'hB1, 32'hA0};
    b_if.out_ready = 1'b0;
    b_if.sel       = 2'd3;
    b_if.in_valid  = 1'b1;
    n_checks++; if (b_if.err_sticky !== 1'b0) begin n_fail++;
      $display("FAIL ill_sticky_pre: got %b want 0", b_if.err_sticky); end
    step();
    b_if.in_valid = 1'b0;
    n_checks++; if (b_if.out_valid !== 1'b1 || b_if.out_data !== 32'hA0) begin n_fail++;
      $display("FAIL ill_data: valid %b data %h want 1 a0", b_if.out_valid, b_if.out_data); end
    n_checks++; if (b_if.out_sel_err !== ERR_EN) begin n_fail++;
      $display("FAIL ill_sel_err: got %b want %b", b_if.out_sel_err, ERR_EN); end
    n_checks++; if (b_if.err_sticky !== ERR_EN) begin n_fail++;
      $display("FAIL ill_sticky: got %b want %b", b_if.err_sticky, ERR_EN); end
    step();
    n_checks++; if (b_if.out_data !== 32'hA0 || b_if.out_sel_err !== ERR_EN) begin n_fail++;
      $display("FAIL ill_stable: data %h err %b want a0 %b", b_if.out_data,
               b_if.out_sel_err, ERR_EN); end
    b_if.out_ready = 1'b1;
    step();
    b_if.sel      = 2'd1;
    b_if.in_valid = 1'b1;
    step();
    b_if.in_valid = 1'b0;
    n_checks++; if (b_if.out_data !== 32'hB1 || b_if.out_sel_err !== 1'b0) begin n_fail++;
      $display("FAIL ill_legal: data %h err %b want b1 0", b_if.out_data, b_if.out_sel_err); end
    n_checks++; if (b_if.err_sticky !== ERR_EN) begin n_fail++;
      $display("FAIL ill_sticky_hold: got %b want %b", b_if.err_sticky, ERR_EN); end
    step();
  endtask

  task automatic test_reset_mid();
    s = '{32'h5a, 32'h6b, 32'h7c, 32'h8d};
    a_if.src_data  = {s[3], s[2], s[1], s[0]};
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 1'b1;
    a_if.sel       = 2'd0;
    step();
    a_if.sel = 2'd1;
    step();
    n_checks++; if (a_if.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL rmid_two: in_ready got %b want 0", a_if.in_ready); end
    a_if.sel = 2'd3;
    rst      = 1'b1;
    step();
    rst           = 1'b0;
    a_if.in_valid = 1'b0;
    n_checks++; if (a_if.out_valid !== 1'b0 || a_if.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rmid_state: valid %b ready %b want 0 1", a_if.out_valid, a_if.in_ready); end
    n_checks++; if (b_if.err_sticky !== 1'b0) begin n_fail++;
      $display("FAIL rmid_sticky_clear: got %b want 0", b_if.err_sticky); end
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (a_if.out_valid !== 1'b0) begin n_fail++;
        $display("FAIL rmid_no_emit c%0d: out_valid got %b data %h want 0", i,
                 a_if.out_valid, a_if.out_data); end
    end
  endtask

  task automatic test_wide();
    logic [63:0] src[5] = '{64'h0123_4567_89AB_CDEF, 64'h1111, 64'h2222, 64'h3333,
                            64'hDEAD_BEEF_0000_0001};
    logic [63:0] exp;
    c_if.src_data  = {src[4], src[3], src[2], src[1], src[0]};
    c_if.out_ready = 1'b1;
    c_if.sel       = 3'd4;
    c_if.in_valid  = 1'b1;
    sbw.push_back(src[4]);
    step();
    c_if.sel = 3'd7;
    sbw.push_back(src[0]);
    exp = sbw.pop_front();
    n_checks++; if (c_if.out_valid !== 1'b1 || c_if.out_data !== exp) begin n_fail++;
      $display("FAIL wide_data: valid %b data %h want 1 %h", c_if.out_valid, c_if.out_data, exp); end
    n_checks++; if (c_if.out_sel_err !== 1'b0) begin n_fail++;
      $display("FAIL wide_err_legal: got %b want 0", c_if.out_sel_err); end
    step();
    c_if.in_valid = 1'b0;
    exp = sbw.pop_front();
    n_checks++; if (c_if.out_data !== exp || c_if.out_sel_err !== ERR_EN) begin n_fail++;
      $display("FAIL wide_oob: data %h err %b want %h %b", c_if.out_data, c_if.out_sel_err,
               exp, ERR_EN); end
    step();
    n_checks++; if (c_if.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL wide_end: out_valid got %b want 0", c_if.out_valid); end
  endtask

  initial begin
    a_if.src_data = '0; a_if.sel = '0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
    b_if.src_data = '0; b_if.sel = '0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;
    c_if.src_data = '0; c_if.sel = '0; c_if.in_valid = 1'b0; c_if.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_illegal_sel();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
